// File: rtl/axi_read_arbiter_if.sv
// AXI read address/data channel bundle, N lanes wide on the request side.
// Requesters use N = number of masters; the single downstream port uses N = 1.
interface axi_read_arbiter_if #(
  parameter int unsigned N          = 1,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ID_WIDTH   = 4
);
  logic [N-1:0]          arvalid;
  logic [N-1:0]          arready;
  logic [N*32-1:0]       araddr;
  logic [N*8-1:0]        arlen;
  logic [N*3-1:0]        arsize;
  logic [N*2-1:0]        arburst;
  logic [N*ID_WIDTH-1:0] arid;
  logic [N-1:0]          rvalid;
  logic [N-1:0]          rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic [ID_WIDTH-1:0]   rid;

  // Initiator of read bursts
  modport master (
    output arvalid, araddr, arlen, arsize, arburst, arid, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  // Responder to read bursts
  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter folding N AXI read requesters onto one AXI read port,
// one burst in flight, with a sticky burst-length consistency flag.
module axi_read_arbiter #(
  parameter  int unsigned NUM_MASTERS = 2,
  parameter  int unsigned DATA_WIDTH  = 128,
  parameter  int unsigned ID_WIDTH    = 4,
  localparam int unsigned IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic               clock,
  input  logic               reset,
  axi_read_arbiter_if.slave  m,
  axi_read_arbiter_if.master s,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               busy,
  output logic               len_err
);

  localparam int unsigned CNT_W = 9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0]         addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic [ID_WIDTH-1:0] id;
  } ar_req_t;

  state_e           state_q,    state_d;
  logic [IDX_W-1:0] rr_ptr_q,   rr_ptr_d;
  logic [IDX_W-1:0] grant_q,    grant_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             len_err_q,  len_err_d;
  ar_req_t          ar_q,       ar_d;

  logic             found;
  logic [IDX_W-1:0] winner;
  logic             rready_sel;
  logic             beat;

  // First requester at or after rr_ptr, wrapping modulo NUM_MASTERS
  always_comb begin
    int unsigned idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_MASTERS;
      if (!found && m.arvalid[idx]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

  assign rready_sel = m.rready[grant_q];
  assign beat       = (state_q == S_R) && s.rvalid[0] && rready_sel;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    len_err_d  = len_err_q;
    ar_d       = ar_q;
    m.arready  = '0;
    m.rvalid   = '0;
    s.rready   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          m.arready[winner] = 1'b1;
          ar_d.addr  = m.araddr[winner*32 +: 32];
          ar_d.len   = m.arlen[winner*8 +: 8];
          ar_d.size  = m.arsize[winner*3 +: 3];
          ar_d.burst = m.arburst[winner*2 +: 2];
          ar_d.id    = m.arid[winner*ID_WIDTH +: ID_WIDTH];
          grant_d    = winner;
          beat_cnt_d = '0;
          state_d    = S_AR;
        end
      end
      S_AR: begin
        if (s.arready[0]) state_d = S_R;
      end
      S_R: begin
        s.rready[0]       = rready_sel;
        m.rvalid[grant_q] = s.rvalid[0];
        if (beat) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          // Flag a burst whose rlast disagrees with the arlen that was issued
          if (s.rlast) begin
            if (beat_cnt_q != {1'b0, ar_q.len}) len_err_d = 1'b1;
            rr_ptr_d = IDX_W'((32'(grant_q) + 1) % NUM_MASTERS);
            state_d  = S_IDLE;
          end else if (beat_cnt_q == {1'b0, ar_q.len}) begin
            len_err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
      ar_q       <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      len_err_q  <= len_err_d;
      ar_q       <= ar_d;
    end
  end

  assign s.arvalid[0] = (state_q == S_AR);
  assign s.araddr     = ar_q.addr;
  assign s.arlen      = ar_q.len;
  assign s.arsize     = ar_q.size;
  assign s.arburst    = ar_q.burst;
  assign s.arid       = ar_q.id;

  // Read data is broadcast; only the granted m_rvalid bit qualifies it
  assign m.rdata = DATA_WIDTH'(s.rdata);
  assign m.rresp = s.rresp;
  assign m.rlast = s.rlast;
  assign m.rid   = s.rid;

  assign grant_idx = grant_q;
  assign busy      = (state_q != S_IDLE);
  assign len_err   = len_err_q;

endmodule
